mul_writeback_unit: RTL and testbench

Iterative 64-bit unsigned multiplier that sits between the register-file read ports and the register-file write port. It consumes the two 64-bit operands read from the register file (Out1/Out2), computes the product over 64 clock cycles using radix-2 shift-add, and drives the write-back triple (WReg, Data, WE) for one cycle. It is used for MUL and, when configured, UMULH. The core stalls on Busy while a multiply is in flight.

---
 rtl/mul_writeback_unit.sv | 162 ++++++++++++++++
 tb/tb_mul_writeback_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_writeback_unit.sv
// Iterative 64x64 unsigned radix-2 shift-add multiplier feeding the register-file write port.
// Optional macro MUL_HIGH_EN: honours High and returns the upper product half (UMULH).
module mul_writeback_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [4:0]  Rd,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        High,
  output logic        Busy,
  output logic        Done,
  output logic [4:0]  WReg,
  output logic [63:0] Data,
  output logic        WE
);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_e;

  localparam logic [4:0] XZR      = 5'd31;
  localparam logic [5:0] LAST_ITER = 6'd63;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [63:0] data_q, data_d;

`ifdef MUL_HIGH_EN
  logic [63:0]  a_q, a_d;
  logic         high_q, high_d;
  logic [128:0] p_q, p_d;
  logic [64:0]  sum;
  logic [128:0] p_pre;
  // Bit 128 is always zero at the start of an iteration because every step shifts it out.
  logic         unused_p_msb;
  assign unused_p_msb = p_q[128];
`else
  // Low-half-only datapath: accumulator plus a left-shifting multiplicand.
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] mplier_q, mplier_d;
  logic        unused_high;
  assign unused_high = High;
`endif

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    data_d  = data_q;
`ifdef MUL_HIGH_EN
    a_d     = a_q;
    high_d  = high_q;
    p_d     = p_q;
    sum     = {1'b0, p_q[127:64]};
    p_pre   = p_q;
`else
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          rd_d    = Rd;
          cnt_d   = 6'd0;
          state_d = CALC;
`ifdef MUL_HIGH_EN
          a_d     = A;
          high_d  = High;
          p_d     = {65'b0, B};
`else
          acc_d    = 64'd0;
          mcand_d  = A;
          mplier_d = B;
`endif
        end
      end

      CALC: begin
`ifdef MUL_HIGH_EN
        if (p_q[0]) sum = {1'b0, p_q[127:64]} + {1'b0, a_q};
        p_pre = {sum, p_q[63:0]};
        p_d   = {1'b0, p_pre[128:1]};
`else
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`endif
        cnt_d = cnt_q + 6'd1;

        if (cnt_q == LAST_ITER) begin
`ifdef MUL_HIGH_EN
          data_d = high_q ? p_d[127:64] : p_d[63:0];
`else
          data_d = acc_d;
`endif
          wreg_d  = rd_q;
          done_d  = 1'b1;
          we_d    = (rd_q != XZR);
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      rd_q     <= 5'd0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      wreg_q   <= 5'd0;
      data_q   <= 64'd0;
`ifdef MUL_HIGH_EN
      a_q      <= 64'd0;
      high_q   <= 1'b0;
      p_q      <= 129'd0;
`else
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 64'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      data_q   <= data_d;
`ifdef MUL_HIGH_EN
      a_q      <= a_d;
      high_q   <= high_d;
      p_q      <= p_d;
`else
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign Busy = (state_q == CALC);
  assign Done = done_q;
  assign WE   = we_q;
  assign WReg = wreg_q;
  assign Data = data_q;

endmodule

// File: tb/tb_mul_writeback_unit.sv
// Scoreboard bench for mul_writeback_unit: expected write-backs are queued at issue and
// popped when Done pulses; latency, handshake and reset behaviour are checked inline.
module tb_mul_writeback_unit;

  logic        Clk, Rst, Start, High;
  logic [4:0]  Rd;
  logic [63:0] A, B;
  logic        Busy, Done, WE;
  logic [4:0]  WReg;
  logic [63:0] Data;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] last_data = 64'd0;

  mul_writeback_unit dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Rd(Rd), .A(A), .B(B), .High(High),
    .Busy(Busy), .Done(Done), .WReg(WReg), .Data(Data), .WE(WE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic high);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
`ifdef MUL_HIGH_EN
    return high ? p[127:64] : p[63:0];
`else
    return (high & 1'b0) ? p[127:64] : p[63:0];
`endif
  endfunction

  // Drive a request (at a negedge) and queue its expected write-back.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input logic high);
    exp_t e;
    A = a; B = b; Rd = rd; High = high; Start = 1'b1;
    e.rd = rd; e.we = (rd != 5'd31); e.data = model(a, b, high);
    sb.push_back(e);
  endtask

  // Called with Start high just before the accepting edge; optionally pulses a stray Start
  // at CALC edge ignore_at, optionally asserts reset inside the Done cycle.
  task automatic wait_done(input int ignore_at, input bit rst_in_done);
    int   lat = -1;
    bit   busy_ok = 1'b1;
    exp_t e;
    for (int n = 0; n <= 200; n++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (n == ignore_at - 1) begin
        Start = 1'b1; A = ~A; B = B + 64'd7; Rd = Rd ^ 5'd1; High = ~High;
      end
      if (n == 0) begin
        n_cmp++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
          n_bad++; $display("FAIL accept: Busy=%b Done=%b, want Busy=1 Done=0", Busy, Done);
        end
      end
      if (Done === 1'b1) begin lat = n; break; end
      if (Busy !== 1'b1) busy_ok = 1'b0;
    end
    Start = 1'b0;
    n_cmp++;
    if (lat != 64) begin n_bad++; $display("FAIL latency: got %0d edges, want 64", lat); end
    n_cmp++;
    if (!busy_ok) begin n_bad++; $display("FAIL busy_hold: Busy dropped during CALC, want 1"); end
    if (lat >= 0) begin
      n_cmp++;
      if (Busy !== 1'b0) begin n_bad++; $display("FAIL busy_done: Busy=%b want 0", Busy); end
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++; $display("FAIL sb_empty: Done with no queued op, Data=%h", Data);
      end else begin
        e = sb.pop_front();
        last_data = e.data;
        if (Data !== e.data || WReg !== e.rd || WE !== e.we) begin
          n_bad++;
          $display("FAIL result: Data=%h WReg=%0d WE=%b, want Data=%h WReg=%0d WE=%b",
                   Data, WReg, WE, e.data, e.rd, e.we);
        end
      end
    end
    if (rst_in_done) begin
      #2 Rst = 1'b1;
      #1;
      n_cmp++;
      if (Done !== 1'b0 || WE !== 1'b0) begin
        n_bad++; $display("FAIL rst_done: Done=%b WE=%b, want 0 0", Done, WE);
      end
      last_data = 64'd0;
      @(negedge Clk) Rst = 1'b0;
    end
  endtask

  task automatic check_quiet();
    @(negedge Clk);
    n_cmp++;
    if (Done !== 1'b0 || WE !== 1'b0 || Busy !== 1'b0 || Data !== last_data) begin
      n_bad++;
      $display("FAIL quiet: Done=%b WE=%b Busy=%b Data=%h, want 0 0 0 %h",
               Done, WE, Busy, Data, last_data);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({Busy, Done, WE, WReg, Data} !== 72'd0) begin
      n_bad++; $display("FAIL reset: Busy=%b Done=%b WE=%b WReg=%0d Data=%h, want all 0",
                        Busy, Done, WE, WReg, Data);
    end
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({Busy, Done, WE} !== 3'b000) begin
      n_bad++; $display("FAIL reset_idle: Busy=%b Done=%b WE=%b, want 0 0 0", Busy, Done, WE);
    end
  endtask

  task automatic test_basic();
    issue(64'd3, 64'd5, 5'd2, 1'b0);
    wait_done(-1, 1'b0);
    check_quiet();
  endtask

  task automatic test_patterns();
    logic [63:0] ta [7];
    logic [63:0] tb [7];
    logic        th [7];
    ta = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
           64'h8000_0000_0000_0000, 64'h0, 64'h1, {$urandom, $urandom}};
    tb = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd2,
           64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, {$urandom, $urandom}};
    th = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      issue(ta[i], tb[i], 5'(i + 4), th[i]);
      wait_done(-1, 1'b0);
      check_quiet();
    end
  endtask

  task automatic test_xzr();
    @(negedge Clk);
    issue(64'h1234, 64'd0, 5'd31, 1'b0);
    wait_done(-1, 1'b0);
    check_quiet();
  endtask

  task automatic test_ignore_start();
    @(negedge Clk);
    issue(64'h0123_4567_89AB_CDEF, 64'h0000_0000_0F0F_0F0F, 5'd12, 1'b1);
    wait_done(10, 1'b0);
    check_quiet();
  endtask

  task automatic test_back_to_back();
    @(negedge Clk);
    issue(64'd1000, 64'd1000, 5'd20, 1'b0);
    wait_done(-1, 1'b0);
    issue(64'hCAFE_F00D_1234_5678, 64'h0000_0001_0000_0003, 5'd21, 1'b1);
    wait_done(-1, 1'b0);
    check_quiet();
  endtask

  task automatic test_reset_abort();
    bit   no_done = 1'b1;
    exp_t e;
    @(negedge Clk);
    issue(64'd77, 64'd99, 5'd9, 1'b0);
    repeat (30) begin @(negedge Clk); Start = 1'b0; end
    #2 Rst = 1'b1;
    #1;
    n_cmp++;
    if ({Busy, Done, WE, WReg, Data} !== 72'd0) begin
      n_bad++; $display("FAIL rst_abort: Busy=%b Done=%b WE=%b WReg=%0d Data=%h, want all 0",
                        Busy, Done, WE, WReg, Data);
    end
    e = sb.pop_front();
    last_data = 64'd0;
    @(negedge Clk) Rst = 1'b0;
    repeat (80) begin
      @(negedge Clk);
      if (Done !== 1'b0 || Busy !== 1'b0) no_done = 1'b0;
    end
    n_cmp++;
    if (!no_done) begin n_bad++; $display("FAIL abort_quiet: activity after abort, want none"); end
    issue(64'd6, 64'd7, 5'd3, 1'b0);
    wait_done(-1, 1'b0);
    check_quiet();
  endtask

  task automatic test_reset_in_done();
    @(negedge Clk);
    issue(64'd11, 64'd13, 5'd14, 1'b0);
    wait_done(-1, 1'b1);
    check_quiet();
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Rd = 5'd0; A = 64'd0; B = 64'd0; High = 1'b0;
    test_reset();
    test_basic();
    test_patterns();
    test_xzr();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_reset_in_done();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_leftover: %0d ops never completed, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
